// File: rtl/arithmetic_reduce_pkg.sv
// Shared types and constants for the streaming arithmetic-reduce block.
package arithmetic_reduce_pkg;

    typedef enum logic [1:0] {
        AR_ADD = 2'd0,
        AR_SUB = 2'd1,
        AR_XOR = 2'd2,
        AR_MUL = 2'd3
    } ar_mode_e;

    localparam logic ACC_AND_IDLE = 1'b1;
    localparam logic ACC_OR_IDLE  = 1'b0;

endpackage

// File: rtl/arithmetic_reduce_expr.sv
// Mode-selected W-bit unsigned expression; carries and high product bits drop.
module arithmetic_reduce_expr
    import arithmetic_reduce_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    input  ar_mode_e     mode,
    output logic [W-1:0] expr
);

    always_comb begin
        expr = '0;
        case (mode)
            AR_ADD:  expr = p + q;
            AR_SUB:  expr = p - q;
            AR_XOR:  expr = p ^ q;
            AR_MUL:  expr = p * q;
            default: expr = '0;
        endcase
    end

endmodule

// File: rtl/arithmetic_reduce_stream.sv
// Two-stage valid/ready pipeline computing a per-beat expression with
// per-frame AND/OR reductions and a saturating beat counter.
module arithmetic_reduce_stream
    import arithmetic_reduce_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*W-1:0]  in_flat,
    input  logic [1:0]      in_mode,
    input  logic            in_last,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W+1:0]    out_flat,
    output logic [CW-1:0]   out_beat_cnt,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int unsigned FW = W + 2;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic           en;
    logic [W-1:0]   s1_p;
    logic [W-1:0]   s1_q;
    ar_mode_e       s1_mode;
    logic           s1_last;
    logic           s1_valid;

    logic           acc_and;
    logic           acc_or;
    logic [CW-1:0]  acc_cnt;

    logic [W-1:0]   expr_c;
    logic           red_and_c;
    logic           red_or_c;
    logic [CW-1:0]  beat_cnt_c;

    // Whole pipeline advances together; a stalled output freezes everything.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    arithmetic_reduce_expr #(.W(W)) u_expr (
        .p    (s1_p),
        .q    (s1_q),
        .mode (s1_mode),
        .expr (expr_c)
    );

    always_comb begin
        red_and_c  = acc_and & (&expr_c);
        red_or_c   = acc_or  | (|expr_c);
        beat_cnt_c = (acc_cnt == CNT_MAX) ? CNT_MAX : acc_cnt + CW'(1);
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p     <= '0;
            s1_q     <= '0;
            s1_mode  <= AR_ADD;
            s1_last  <= 1'b0;
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_p     <= in_flat[2*W-1:W];
            s1_q     <= in_flat[W-1:0];
            s1_mode  <= ar_mode_e'(in_mode);
            s1_last  <= in_last;
            s1_valid <= in_valid;
        end
    end

    // Stage 2: result registers and frame accumulators; bubbles leave state alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_flat     <= '0;
            out_beat_cnt <= '0;
            out_last     <= 1'b0;
            acc_and      <= ACC_AND_IDLE;
            acc_or       <= ACC_OR_IDLE;
            acc_cnt      <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_flat     <= FW'({expr_c, red_and_c, red_or_c});
                out_beat_cnt <= beat_cnt_c;
                out_last     <= s1_last;
                if (s1_last) begin
                    acc_and <= ACC_AND_IDLE;
                    acc_or  <= ACC_OR_IDLE;
                    acc_cnt <= '0;
                end else begin
                    acc_and <= red_and_c;
                    acc_or  <= red_or_c;
                    acc_cnt <= beat_cnt_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_arithmetic_reduce_stream.sv
// Self-checking bench: directed vector table, stall/reset sequences,
// randomized traffic against a frame-level reference model, CW=2 saturation.
module tb_arithmetic_reduce_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_flat;
    logic [1:0]  in_mode;
    logic        in_last, in_valid, in_ready;
    logic [9:0]  out_flat;
    logic [15:0] out_beat_cnt;
    logic        out_last, out_valid, out_ready;

    logic [15:0] d2_in_flat;
    logic [1:0]  d2_in_mode;
    logic        d2_in_last, d2_in_valid, d2_in_ready;
    logic [9:0]  d2_out_flat;
    logic [1:0]  d2_out_beat_cnt;
    logic        d2_out_last, d2_out_valid, d2_out_ready;

    always #5 clk = ~clk;

    arithmetic_reduce_stream #(.W(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_flat(in_flat), .in_mode(in_mode),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_flat(out_flat), .out_beat_cnt(out_beat_cnt), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    arithmetic_reduce_stream #(.W(8), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .in_flat(d2_in_flat), .in_mode(d2_in_mode),
        .in_last(d2_in_last), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .out_flat(d2_out_flat), .out_beat_cnt(d2_out_beat_cnt), .out_last(d2_out_last),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready)
    );

    typedef struct {
        logic [15:0] flat;
        logic [1:0]  mode;
        logic        last;
        logic [7:0]  e_expr;
        logic        e_and;
        logic        e_or;
        logic [15:0] e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected results of accepted beats, in order.
    logic [26:0] exp_q[$];
    logic        m_and = 1'b1;
    logic        m_or  = 1'b0;
    int          m_cnt = 0;

    logic        have_prev = 1'b0;
    logic [26:0] prev_out;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [7:0] ref_expr(input logic [15:0] f, input logic [1:0] m);
        int p, q, r;
        p = int'(f[15:8]);
        q = int'(f[7:0]);
        case (m)
            2'd0:    r = p + q;
            2'd1:    r = p - q + 256;
            2'd2:    r = p ^ q;
            default: r = p * q;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic model_reset();
        m_and = 1'b1;
        m_or  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_push(input logic [15:0] f, input logic [1:0] m, input logic l);
        logic [7:0] e;
        e = ref_expr(f, m);
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_and = m_and && (e == 8'hFF);
        m_or  = m_or  || (e != 8'h00);
        exp_q.push_back({e, m_and, m_or, 16'(m_cnt), l});
        if (l) model_reset();
    endtask

    // One clock of the main DUT: drive at negedge, check, advance to next negedge.
    task automatic step(input logic v, input logic [15:0] f, input logic [1:0] m,
                        input logic l, input logic r, output logic acc);
        logic [26:0] cur;
        logic [26:0] e;
        in_valid = v; in_flat = f; in_mode = m; in_last = l; out_ready = r;
        #1;
        cur = {out_flat, out_beat_cnt, out_last};
        if (have_prev) begin
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_data", 32'(cur), 32'(prev_out));
        end
        if (out_valid && !out_ready) check("in_ready_stalled", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(cur), 32'h7FFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("stream_result", 32'(cur), 32'(e));
            end
        end
        acc = v && in_ready;
        if (acc) model_push(f, m, l);
        have_prev = out_valid && !out_ready;
        prev_out  = cur;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] f, input logic [1:0] m, input logic l, input logic r);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) step(1'b1, f, m, l, r, acc);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input logic r);
        logic acc;
        step(1'b0, 16'h0, 2'd0, 1'b0, r, acc);
    endtask

    vec_t tbl[7];
    logic acc_d;

    initial begin
        tbl[0] = '{16'h0F01, 2'd0, 1'b1, 8'h10, 1'b0, 1'b1, 16'd1};
        tbl[1] = '{16'h0001, 2'd1, 1'b1, 8'hFF, 1'b1, 1'b1, 16'd1};
        tbl[2] = '{16'h1010, 2'd3, 1'b1, 8'h00, 1'b0, 1'b0, 16'd1};
        tbl[3] = '{16'hF00F, 2'd2, 1'b0, 8'hFF, 1'b1, 1'b1, 16'd1};
        tbl[4] = '{16'hAA55, 2'd2, 1'b0, 8'hFF, 1'b1, 1'b1, 16'd2};
        tbl[5] = '{16'h7F00, 2'd2, 1'b1, 8'h7F, 1'b0, 1'b1, 16'd3};
        tbl[6] = '{16'h0101, 2'd0, 1'b1, 8'h02, 1'b0, 1'b1, 16'd1};

        rst = 1'b1;
        in_valid = 0; in_flat = 0; in_mode = 0; in_last = 0; out_ready = 1;
        d2_in_valid = 0; d2_in_flat = 0; d2_in_mode = 0; d2_in_last = 0; d2_out_ready = 1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'({out_flat, out_beat_cnt, out_last}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed table: each vector alone, checked exactly two edges after drive.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].flat, tbl[i].mode, tbl[i].last, 1'b1);
            idle(1'b1);
            check("tbl_latency_valid", 32'(out_valid), 32'd1);
            check("tbl_expr_and_or", 32'(out_flat), 32'({tbl[i].e_expr, tbl[i].e_and, tbl[i].e_or}));
            check("tbl_beat_cnt", 32'(out_beat_cnt), 32'(tbl[i].e_cnt));
            check("tbl_last", 32'(out_last), 32'(tbl[i].last));
        end
        idle(1'b1);

        // Back-to-back 4-beat frame with the output stalled for 4 cycles.
        step(1'b1, 16'h0102, 2'd0, 1'b0, 1'b0, acc_d);
        step(1'b1, 16'h0903, 2'd1, 1'b0, 1'b0, acc_d);
        step(1'b1, 16'hFF00, 2'd2, 1'b0, 1'b0, acc_d);
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, 16'hFF00, 2'd2, 1'b0, 1'b0, acc_d);
        send(16'hFF00, 2'd2, 1'b0, 1'b1);
        send(16'h0303, 2'd3, 1'b1, 1'b1);
        send(16'h0505, 2'd2, 1'b1, 1'b1);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) idle(1'b1);
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame.
        send(16'hFF00, 2'd2, 1'b0, 1'b1);
        send(16'hFF00, 2'd2, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        model_reset();
        have_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(16'h0000, 2'd0, 1'b1, 1'b1);
        idle(1'b1);
        check("post_reset_beat", 32'({out_valid, out_flat, out_beat_cnt, out_last}),
              32'({1'b1, 8'h00, 1'b0, 1'b0, 16'd1, 1'b1}));
        idle(1'b1);

        // Randomized traffic with random bubbles and backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] f;
            f = 16'($urandom);
            if ($urandom_range(0, 3) == 0) f = {f[15:8], ~f[15:8]};
            step($urandom_range(0, 3) != 0, f, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, acc_d);
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1'b1);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Saturating counter on the CW=2 instance.
        begin
            logic [1:0] sat_exp[5];
            int idx;
            sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
            sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
            idx = 0;
            for (int c = 0; c < 12; c++) begin
                d2_in_valid = (c < 5);
                d2_in_flat  = 16'hFF00;
                d2_in_mode  = 2'd2;
                d2_in_last  = (c == 4);
                #1;
                if (d2_out_valid && idx < 5) begin
                    check("sat_cnt", 32'(d2_out_beat_cnt), 32'(sat_exp[idx]));
                    check("sat_red", 32'(d2_out_flat), 32'({8'hFF, 1'b1, 1'b1}));
                    check("sat_last", 32'(d2_out_last), 32'(idx == 4));
                    idx++;
                end
                @(posedge clk);
                @(negedge clk);
            end
            check("sat_count_beats", 32'(idx), 32'd5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
